// File: rtl/mic_pkg.sv
// mic_pkg: frame geometry and FSM state type shared by the microphone capture path.
package mic_pkg;
  localparam int MIC_FRAME_BITS = 16;
  localparam int MIC_LEAD_BITS  = 4;
  localparam int MIC_DATA_BITS  = 12;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} mic_state_t;
endpackage

// File: rtl/mic_spi_capture_if.sv
// mic_spi_capture_if: ADC SPI pins plus the parallel sample/strobe outputs of the capture stage.
interface mic_spi_capture_if;
  import mic_pkg::*;
  logic                     mic_miso;
  logic                     mic_cs_n;
  logic                     mic_sclk;
  logic [MIC_DATA_BITS-1:0] mic_sample;
  logic                     sample_valid;
  logic                     overrun;
  logic                     frame_error;
  modport master (
    input  mic_miso,
    output mic_cs_n, mic_sclk, mic_sample, sample_valid, overrun, frame_error
  );
  modport slave (
    output mic_miso,
    input  mic_cs_n, mic_sclk, mic_sample, sample_valid, overrun, frame_error
  );
endinterface

// File: rtl/mic_tick_gen.sv
// mic_tick_gen: modulo-N counter with enable, synchronous clear and terminal-count pulse.
module mic_tick_gen #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = en_i && cnt_q == W'(N - 1);
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mic_spi_capture.sv
// mic_spi_capture: runs one ADCS7476 SPI frame per sample period and presents the 12-bit result.
// Define MIC_FRAME_CHECK_EN to drop frames with non-zero leading bits and pulse frame_error.
module mic_spi_capture
  import mic_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int SAMPLE_DIV = 5000
) (
  input logic               clock,
  input logic               reset_n,
  mic_spi_capture_if.master bus
);
  mic_state_t                state_q;
  logic                      cs_n_q, sclk_q, valid_q, overrun_q;
  logic [4:0]                bit_q;
  logic [MIC_FRAME_BITS-1:0] shift_q;
  logic [MIC_DATA_BITS-1:0]  sample_q;
  logic                      start, half_tc, frame_end, frame_bad;
  mic_tick_gen #(.N(SAMPLE_DIV)) u_sample_tmr (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (1'b1),
    .clr_i   (1'b0),
    .tc_o    (start)
  );
  mic_tick_gen #(.N(CLK_DIV)) u_half_tmr (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (state_q == SHIFT),
    .clr_i   (state_q == IDLE && start),
    .tc_o    (half_tc)
  );
  assign frame_end = state_q == SHIFT && bit_q == 5'(MIC_FRAME_BITS);
`ifdef MIC_FRAME_CHECK_EN
  logic ferr_q;
  assign frame_bad = |shift_q[MIC_FRAME_BITS-1 -: MIC_LEAD_BITS];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ferr_q <= 1'b0;
    else ferr_q <= frame_end && frame_bad;
  assign bus.frame_error = ferr_q;
`else
  logic unused_lead;
  assign unused_lead     = ^shift_q[MIC_FRAME_BITS-1 -: MIC_LEAD_BITS];
  assign frame_bad       = 1'b0;
  assign bus.frame_error = 1'b0;
`endif
  // Outputs are registered so cs_n, sample and strobe all change together on entry to DONE.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      bit_q     <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= start && state_q != IDLE;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SHIFT;
          cs_n_q  <= 1'b0;
          sclk_q  <= 1'b1;
          bit_q   <= '0;
        end
        SHIFT: if (frame_end) begin
          state_q <= DONE;
          cs_n_q  <= 1'b1;
          if (!frame_bad) begin
            sample_q <= shift_q[MIC_DATA_BITS-1:0];
            valid_q  <= 1'b1;
          end
        end else if (half_tc) begin
          sclk_q <= ~sclk_q;
          if (!sclk_q) begin
            shift_q <= {shift_q[MIC_FRAME_BITS-2:0], bus.mic_miso};
            bit_q   <= bit_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.mic_cs_n     = cs_n_q;
  assign bus.mic_sclk     = sclk_q;
  assign bus.mic_sample   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_mic_spi_capture.sv
// tb_mic_spi_capture: nominal-rate and overrunning capture instances against a behavioural ADC and timing model.
module tb_mic_spi_capture;
  localparam int CA = 50, SA = 5000, CB = 4, SB = 100;
  logic clock = 1'b0;
  logic rst_a_n = 1'b1, rst_b_n = 1'b1;
  int vectors = 0, errors = 0, cyc = 0, falls_b = 0;
  int idx [2], rises [2], ovr [2];
  logic [15:0] word [2];
  logic [11:0] exp_s [2];
  mic_spi_capture_if ia ();
  mic_spi_capture_if ib ();
  mic_spi_capture #(.CLK_DIV(CA), .SAMPLE_DIV(SA)) u_a (.clock(clock), .reset_n(rst_a_n), .bus(ia));
  mic_spi_capture #(.CLK_DIV(CB), .SAMPLE_DIV(SB)) u_b (.clock(clock), .reset_n(rst_b_n), .bus(ib));
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (ia.overrun) ovr[0]++;
    if (ib.overrun) ovr[1]++;
  end
  // ADC model: each falling SCLK inside a frame presents the next bit, MSB first.
  always @(negedge ia.mic_cs_n) begin idx[0] = 0; rises[0] = 0; end
  always @(negedge ia.mic_sclk) if (!ia.mic_cs_n && idx[0] < 16) begin ia.mic_miso = word[0][4'(15 - idx[0])]; idx[0]++; end
  always @(posedge ia.mic_sclk) if (!ia.mic_cs_n) rises[0]++;
  always @(negedge ib.mic_cs_n) begin idx[1] = 0; rises[1] = 0; falls_b++; end
  always @(negedge ib.mic_sclk) if (!ib.mic_cs_n && idx[1] < 16) begin ib.mic_miso = word[1][4'(15 - idx[1])]; idx[1]++; end
  always @(posedge ib.mic_sclk) if (!ib.mic_cs_n) rises[1]++;

  function automatic logic sig(input int w, input int k);
    logic [4:0] v;
    v = w != 0 ? {ib.mic_cs_n, ib.sample_valid, ib.mic_sclk, ib.frame_error, ib.overrun}
               : {ia.mic_cs_n, ia.sample_valid, ia.mic_sclk, ia.frame_error, ia.overrun};
    return v[3'(4 - k)];
  endfunction

  function automatic logic [11:0] samp(input int w);
    return w != 0 ? ib.mic_sample : ia.mic_sample;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input int w, input int k, input logic lvl, input int lim, output int t);
    int n = 0;
    do begin @(negedge clock); n++; end while (sig(w, k) !== lvl && n < lim);
    t = cyc;
    check("wait_bound", 32'(sig(w, k)), 32'(lvl));
  endtask

  task automatic frame(input int w, input logic [15:0] fw, input int t_rel, input int t_prev, output int t_done);
    int tf, c, sd, per;
    logic bad;
    c   = w != 0 ? CB : CA;
    sd  = w != 0 ? SB : SA;
    per = sd * ((32 * c + 3 + sd - 1) / sd);
    word[w] = fw;
    bad = 1'b0;
`ifdef MIC_FRAME_CHECK_EN
    bad = fw[15:12] != 4'd0;
`endif
    if (!bad) exp_s[w] = fw[11:0];
    wait_sig(w, 0, 1'b0, 3 * sd, tf);
    if (t_rel >= 0) check("first_start", 32'(tf - t_rel), 32'(sd));
    wait_sig(w, 0, 1'b1, 40 * c, t_done);
    check("cs_low_len", 32'(t_done - tf), 32'(32 * c + 1));
    check("sclk_rises", 32'(rises[w]), 32'd16);
    check("valid", 32'(sig(w, 1)), 32'(!bad));
    check("frame_error", 32'(sig(w, 3)), 32'(bad));
    check("sample", 32'(samp(w)), 32'(exp_s[w]));
    if (t_prev >= 0) check("period", 32'(t_done - t_prev), 32'(per));
    @(negedge clock);
    check("valid_width", 32'(sig(w, 1)), 32'd0);
    check("sample_hold", 32'(samp(w)), 32'(exp_s[w]));
  endtask

  initial begin
    int t0, tp, tf, n, k;
    word[0] = 16'h0ABC; word[1] = 16'h0;
    exp_s[0] = '0; exp_s[1] = '0;
    ovr[0] = 0; ovr[1] = 0;
    #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cs_n", 32'(ia.mic_cs_n), 32'd1);
    check("rst_sclk", 32'(ia.mic_sclk), 32'd1);
    check("rst_sample", 32'(ia.mic_sample), 32'd0);
    check("rst_valid", 32'(ia.sample_valid), 32'd0);
    check("rst_overrun", 32'(ia.overrun), 32'd0);
    check("rst_frame_error", 32'(ia.frame_error), 32'd0);
    rst_a_n = 1'b1; t0 = cyc;
    frame(0, 16'h0ABC, t0, -1, tp);
    frame(0, 16'h0000, -1, tp, tp);
    frame(0, 16'h0FFF, -1, tp, tp);
    for (int i = 0; i < 3; i++) frame(0, {4'h0, 12'($urandom)}, -1, tp, tp);
    frame(0, 16'h8123, -1, tp, tp);
    frame(0, {4'h0, 12'($urandom)}, -1, tp, tp);
    word[0] = 16'h0555;
    wait_sig(0, 0, 1'b0, 3 * SA, tf);
    n = 0;
    while (!(rises[0] >= 8 && ia.mic_sclk === 1'b0) && n < 40 * CA) begin @(negedge clock); n++; end
    check("mid_rises", 32'(rises[0]), 32'd8);
    check("mid_sclk_low", 32'(ia.mic_sclk), 32'd0);
    #2 rst_a_n = 1'b0;
    #1;
    check("async_cs_n", 32'(ia.mic_cs_n), 32'd1);
    check("async_sclk", 32'(ia.mic_sclk), 32'd1);
    check("async_sample", 32'(ia.mic_sample), 32'd0);
    check("async_valid", 32'(ia.sample_valid), 32'd0);
    exp_s[0] = '0;
    @(negedge clock); rst_a_n = 1'b1; t0 = cyc;
    frame(0, {4'h0, 12'($urandom)}, t0, -1, tp);
    frame(0, {4'h0, 12'($urandom)}, -1, tp, tp);
    check("no_overrun_a", 32'(ovr[0]), 32'd0);
    @(negedge clock); rst_b_n = 1'b1; t0 = cyc; tp = -1;
    k = (32 * CB + 3 + SB - 1) / SB;
    for (int i = 0; i < 3; i++) begin
      frame(1, {4'h0, 12'($urandom)}, i == 0 ? t0 : -1, tp, tp);
      check("overruns", 32'(ovr[1]), 32'((i + 1) * (k - 1)));
      check("cs_falls", 32'(falls_b), 32'(i + 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
